redma_cmd_queue: RTL and testbench

//  Command front-end for the DMA datapath. Accepts DMA jobs on a valid/ready stream, buffers up to

---
 rtl/redma_cmd_queue_if.sv | 35 +++
 rtl/redma_cmd_queue.sv | 202 ++++++++++++++++++++
 tb/tb_redma_cmd_queue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/redma_cmd_queue_if.sv
// Command and status streams of the DMA command queue.
// The master offers jobs and consumes status; the slave is the queue itself.
interface redma_cmd_queue_if #(
    parameter int INTERNAL_RADDR_WIDTH = 32,
    parameter int INTERNAL_WADDR_WIDTH = 32,
    parameter int BTT_WIDTH            = 32,
    parameter int TAG_WIDTH            = 8
) ();
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic [INTERNAL_RADDR_WIDTH-1:0] cmd_raddr;
    logic [INTERNAL_WADDR_WIDTH-1:0] cmd_waddr;
    logic [BTT_WIDTH-1:0]            cmd_btt;
    logic                            cmd_write_zero;
    logic [TAG_WIDTH-1:0]            cmd_tag;

    logic                            sts_valid;
    logic                            sts_ready;
    logic [TAG_WIDTH-1:0]            sts_tag;
    logic                            sts_zero_len;

    modport master (
        output cmd_valid, cmd_raddr, cmd_waddr, cmd_btt, cmd_write_zero, cmd_tag,
        input  cmd_ready,
        input  sts_valid, sts_tag, sts_zero_len,
        output sts_ready
    );

    modport slave (
        input  cmd_valid, cmd_raddr, cmd_waddr, cmd_btt, cmd_write_zero, cmd_tag,
        output cmd_ready,
        output sts_valid, sts_tag, sts_zero_len,
        input  sts_ready
    );
endinterface

// File: rtl/redma_cmd_queue.sv
// DMA command front-end: buffers jobs in a small FIFO, launches them one at a time
// on the engine controls, waits for both done pulses and returns the tag on status.
module redma_cmd_queue #(
    parameter int INTERNAL_RADDR_WIDTH = 32,
    parameter int INTERNAL_WADDR_WIDTH = 32,
    parameter int BTT_WIDTH            = 32,
    parameter int QUEUE_LEN            = 4,
    parameter int TAG_WIDTH            = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    redma_cmd_queue_if.slave                  bus,
    output logic [INTERNAL_RADDR_WIDTH-1:0]   read_start_addr,
    output logic [INTERNAL_WADDR_WIDTH-1:0]   write_start_addr,
    output logic [BTT_WIDTH-1:0]              btt,
    output logic                              write_zero,
    output logic                              reader_start,
    output logic                              writer_start,
    input  logic                              set_reader_intr,
    input  logic                              set_writer_intr,
    output logic                              busy,
    output logic [$clog2(QUEUE_LEN+1)-1:0]    queue_count
);
    localparam int CNT_W   = $clog2(QUEUE_LEN + 1);
    localparam int PTR_W   = (QUEUE_LEN > 1) ? $clog2(QUEUE_LEN) : 1;
    localparam int ENTRY_W = INTERNAL_RADDR_WIDTH + INTERNAL_WADDR_WIDTH + BTT_WIDTH + 1 + TAG_WIDTH;
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(QUEUE_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_REPORT
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [ENTRY_W-1:0] fifo_mem [QUEUE_LEN];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               cmd_ready_reg, cmd_ready_next;
    logic               push, pop;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;

    logic [INTERNAL_RADDR_WIDTH-1:0] head_raddr;
    logic [INTERNAL_WADDR_WIDTH-1:0] head_waddr;
    logic [BTT_WIDTH-1:0]            head_btt;
    logic                            head_write_zero;
    logic [TAG_WIDTH-1:0]            head_tag;

    state_t state_reg;

    assign push     = bus.cmd_valid && cmd_ready_reg;
    assign pop      = (state_reg == ST_IDLE) && (count_reg != '0);
    assign entry_in = {bus.cmd_raddr, bus.cmd_waddr, bus.cmd_btt, bus.cmd_write_zero, bus.cmd_tag};
    assign head     = fifo_mem[rd_ptr_reg];
    assign {head_raddr, head_waddr, head_btt, head_write_zero, head_tag} = head;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
        // Ready is registered from the next count, so it never bypasses a full queue.
        cmd_ready_next = (count_next != FULL_COUNT);
    end

    // Storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            fifo_mem[wr_ptr_reg] <= entry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            cmd_ready_reg <= 1'b1;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            cmd_ready_reg <= cmd_ready_next;
        end
    end

    // ---------------------------------------------------------------- job FSM
    logic [INTERNAL_RADDR_WIDTH-1:0] raddr_reg;
    logic [INTERNAL_WADDR_WIDTH-1:0] waddr_reg;
    logic [BTT_WIDTH-1:0]            btt_reg;
    logic                            write_zero_reg;
    logic                            reader_start_reg;
    logic                            writer_start_reg;
    logic                            rd_done_reg;
    logic                            wr_done_reg;
    logic                            sts_valid_reg;
    logic [TAG_WIDTH-1:0]            sts_tag_reg;
    logic                            sts_zero_len_reg;
    logic                            busy_reg;
    logic                            rd_ok, wr_ok;

    // A pulse arriving in the same cycle as the last flag completes the job.
    assign rd_ok = rd_done_reg | set_reader_intr;
    assign wr_ok = wr_done_reg | set_writer_intr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg        <= ST_IDLE;
            raddr_reg        <= '0;
            waddr_reg        <= '0;
            btt_reg          <= '0;
            write_zero_reg   <= 1'b0;
            reader_start_reg <= 1'b0;
            writer_start_reg <= 1'b0;
            rd_done_reg      <= 1'b0;
            wr_done_reg      <= 1'b0;
            sts_valid_reg    <= 1'b0;
            sts_tag_reg      <= '0;
            sts_zero_len_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            reader_start_reg <= 1'b0;
            writer_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        raddr_reg      <= head_raddr;
                        waddr_reg      <= head_waddr;
                        btt_reg        <= head_btt;
                        write_zero_reg <= head_write_zero;
                        sts_tag_reg    <= head_tag;
                        busy_reg       <= 1'b1;
                        if (head_btt == '0) begin
                            // Empty jobs skip the engines and report straight away.
                            state_reg        <= ST_REPORT;
                            sts_valid_reg    <= 1'b1;
                            sts_zero_len_reg <= 1'b1;
                        end else begin
                            state_reg        <= ST_LAUNCH;
                            writer_start_reg <= 1'b1;
                            reader_start_reg <= !head_write_zero;
                        end
                    end
                end
                ST_LAUNCH: begin
                    // Pulses seen here are dropped; a write-zero job has no read side.
                    rd_done_reg <= write_zero_reg;
                    wr_done_reg <= 1'b0;
                    state_reg   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (set_reader_intr) rd_done_reg <= 1'b1;
                    if (set_writer_intr) wr_done_reg <= 1'b1;
                    if (rd_ok && wr_ok) begin
                        state_reg     <= ST_REPORT;
                        sts_valid_reg <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (bus.sts_ready) begin
                        state_reg        <= ST_IDLE;
                        sts_valid_reg    <= 1'b0;
                        sts_zero_len_reg <= 1'b0;
                        busy_reg         <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_reg;
    assign bus.sts_valid    = sts_valid_reg;
    assign bus.sts_tag      = sts_tag_reg;
    assign bus.sts_zero_len = sts_zero_len_reg;
    assign read_start_addr  = raddr_reg;
    assign write_start_addr = waddr_reg;
    assign btt              = btt_reg;
    assign write_zero       = write_zero_reg;
    assign reader_start     = reader_start_reg;
    assign writer_start     = writer_start_reg;
    assign busy             = busy_reg;
    assign queue_count      = count_reg;

endmodule

// File: tb/tb_redma_cmd_queue.sv
// Directed bench for redma_cmd_queue: latency, write-zero, full queue, zero-length,
// status back-pressure and mid-job reset, each against hand-computed values.
module tb_redma_cmd_queue;
    logic        clk;
    logic        rstn;
    logic [31:0] read_start_addr;
    logic [31:0] write_start_addr;
    logic [31:0] btt;
    logic        write_zero;
    logic        reader_start;
    logic        writer_start;
    logic        set_reader_intr;
    logic        set_writer_intr;
    logic        busy;
    logic [2:0]  queue_count;

    int tests_run;
    int tests_failed;

    redma_cmd_queue_if bus ();

    redma_cmd_queue dut (
        .clk              (clk),
        .rstn             (rstn),
        .bus              (bus.slave),
        .read_start_addr  (read_start_addr),
        .write_start_addr (write_start_addr),
        .btt              (btt),
        .write_zero       (write_zero),
        .reader_start     (reader_start),
        .writer_start     (writer_start),
        .set_reader_intr  (set_reader_intr),
        .set_writer_intr  (set_writer_intr),
        .busy             (busy),
        .queue_count      (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] n,
                        input logic wz, input logic [7:0] tag);
        int waited;
        bus.cmd_raddr      = ra;
        bus.cmd_waddr      = wa;
        bus.cmd_btt        = n;
        bus.cmd_write_zero = wz;
        bus.cmd_tag        = tag;
        bus.cmd_valid      = 1'b1;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        if (waited >= 50) check("push_timeout", 64'd0, 64'd1);
        step();
        bus.cmd_valid = 1'b0;
        $display("[TB] push tag=0x%0h btt=%0d wz=%0d", tag, n, wz);
    endtask

    // Called in a WAIT cycle: pulse the done inputs, expect status next cycle, handshake.
    task automatic finish_job(input logic [7:0] tag, input logic wz);
        set_writer_intr = 1'b1;
        set_reader_intr = !wz;
        step();
        set_writer_intr = 1'b0;
        set_reader_intr = 1'b0;
        check("sts_valid", 64'(bus.sts_valid), 64'd1);
        check("sts_tag", 64'(bus.sts_tag), 64'(tag));
        check("sts_zero_len", 64'(bus.sts_zero_len), 64'd0);
        $display("[TB] status tag=0x%0h zero_len=%0d", bus.sts_tag, bus.sts_zero_len);
        bus.sts_ready = 1'b1;
        step();
        bus.sts_ready = 1'b0;
    endtask

    task automatic run_job(input logic [7:0] tag, input logic wz);
        int waited;
        waited = 0;
        while (writer_start !== 1'b1 && waited < 30) begin
            step();
            waited++;
        end
        check("launch_writer_start", 64'(writer_start), 64'd1);
        check("launch_reader_start", 64'(reader_start), 64'(!wz));
        step();
        finish_job(tag, wz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        rstn               = 1'b0;
        set_reader_intr    = 1'b0;
        set_writer_intr    = 1'b0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_raddr      = '0;
        bus.cmd_waddr      = '0;
        bus.cmd_btt        = '0;
        bus.cmd_write_zero = 1'b0;
        bus.cmd_tag        = '0;
        bus.sts_ready      = 1'b0;
        step();
        step();

        // Reset state
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_queue_count", 64'(queue_count), 64'd0);
        check("rst_flags", 64'({busy, bus.sts_valid, reader_start, writer_start, write_zero}), 64'd0);
        rstn = 1'b1;
        step();

        // 1: single job, writer done then reader done five cycles later
        push(32'h1000, 32'h2000, 32'd256, 1'b0, 8'h11);
        check("t1_count_k1", 64'(queue_count), 64'd1);
        check("t1_no_start_k1", 64'(writer_start), 64'd0);
        step();
        check("t1_writer_start", 64'(writer_start), 64'd1);
        check("t1_reader_start", 64'(reader_start), 64'd1);
        check("t1_raddr", 64'(read_start_addr), 64'h1000);
        check("t1_waddr", 64'(write_start_addr), 64'h2000);
        check("t1_btt", 64'(btt), 64'd256);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_count_after_pop", 64'(queue_count), 64'd0);
        step();
        check("t1_start_is_pulse", 64'({reader_start, writer_start}), 64'd0);
        set_writer_intr = 1'b1;
        step();
        set_writer_intr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t1_no_early_sts", 64'(bus.sts_valid), 64'd0);
            step();
        end
        set_reader_intr = 1'b1;
        check("t1_no_sts_at_last_intr", 64'(bus.sts_valid), 64'd0);
        step();
        set_reader_intr = 1'b0;
        check("t1_sts_valid", 64'(bus.sts_valid), 64'd1);
        check("t1_sts_tag", 64'(bus.sts_tag), 64'h11);
        check("t1_sts_zero_len", 64'(bus.sts_zero_len), 64'd0);
        $display("[TB] status tag=0x%0h zero_len=%0d", bus.sts_tag, bus.sts_zero_len);
        bus.sts_ready = 1'b1;
        step();
        bus.sts_ready = 1'b0;
        check("t1_sts_cleared", 64'(bus.sts_valid), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);

        // 2: write-zero job, only the writer reports done
        push(32'h3000, 32'h4000, 32'd64, 1'b1, 8'h22);
        step();
        check("t2_write_zero_out", 64'(write_zero), 64'd1);
        run_job(8'h22, 1'b1);

        // 3: block the FSM in WAIT, fill the queue, check back-pressure and ordering
        push(32'h5000, 32'h6000, 32'd8, 1'b0, 8'h30);
        step();
        step();
        for (int t = 1; t <= 4; t++) begin
            push(32'(t * 32'h100), 32'(t * 32'h200), 32'(t * 16), 1'b0, 8'(t));
        end
        check("t3_full_count", 64'(queue_count), 64'd4);
        check("t3_full_not_ready", 64'(bus.cmd_ready), 64'd0);
        bus.cmd_raddr = 32'h500;
        bus.cmd_waddr = 32'hA00;
        bus.cmd_btt   = 32'd80;
        bus.cmd_tag   = 8'd5;
        bus.cmd_valid = 1'b1;
        step();
        check("t3_fifth_held_off", 64'(queue_count), 64'd4);
        finish_job(8'h30, 1'b0);
        check("t3_still_full", 64'(bus.cmd_ready), 64'd0);
        step();
        check("t3_launch_job1", 64'(writer_start), 64'd1);
        check("t3_ready_after_pop", 64'(bus.cmd_ready), 64'd1);
        check("t3_count_after_pop", 64'(queue_count), 64'd3);
        step();
        bus.cmd_valid = 1'b0;
        $display("[TB] push tag=0x5 btt=80 wz=0");
        check("t3_fifth_accepted", 64'(queue_count), 64'd4);
        finish_job(8'd1, 1'b0);
        for (int t = 2; t <= 5; t++) begin
            run_job(8'(t), 1'b0);
        end
        check("t3_drained", 64'(queue_count), 64'd0);

        // 4: zero-length job reports without launching
        push(32'h7000, 32'h8000, 32'd0, 1'b0, 8'h07);
        check("t4_no_sts_k1", 64'(bus.sts_valid), 64'd0);
        step();
        check("t4_sts_valid", 64'(bus.sts_valid), 64'd1);
        check("t4_zero_len", 64'(bus.sts_zero_len), 64'd1);
        check("t4_tag", 64'(bus.sts_tag), 64'h07);
        check("t4_no_start", 64'({reader_start, writer_start}), 64'd0);
        bus.sts_ready = 1'b1;
        step();
        bus.sts_ready = 1'b0;
        $display("[TB] status tag=0x7 zero_len=1");
        check("t4_zero_len_cleared", 64'(bus.sts_zero_len), 64'd0);

        // 5: simultaneous done pulses, status held under back-pressure
        push(32'h9000, 32'hA000, 32'd32, 1'b0, 8'h55);
        step();
        step();
        set_writer_intr = 1'b1;
        set_reader_intr = 1'b1;
        step();
        set_writer_intr = 1'b0;
        set_reader_intr = 1'b0;
        bus.cmd_raddr = 32'hB000;
        bus.cmd_waddr = 32'hC000;
        bus.cmd_btt   = 32'd48;
        bus.cmd_tag   = 8'h56;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t5_sts_held", 64'(bus.sts_valid), 64'd1);
            check("t5_tag_held", 64'(bus.sts_tag), 64'h55);
            check("t5_no_launch", 64'(writer_start), 64'd0);
            step();
            bus.cmd_valid = 1'b0;
        end
        check("t5_next_queued", 64'(queue_count), 64'd1);
        $display("[TB] status tag=0x%0h zero_len=%0d", bus.sts_tag, bus.sts_zero_len);
        bus.sts_ready = 1'b1;
        step();
        bus.sts_ready = 1'b0;
        check("t5_idle_after_hs", 64'(busy), 64'd0);
        step();
        check("t5_launch_after_hs", 64'(writer_start), 64'd1);
        check("t5_next_raddr", 64'(read_start_addr), 64'hB000);
        step();
        finish_job(8'h56, 1'b0);

        // 6: reset in WAIT with two queued jobs, stale pulses afterwards
        push(32'hD000, 32'hE000, 32'd16, 1'b0, 8'h60);
        step();
        step();
        push(32'h1, 32'h2, 32'd4, 1'b0, 8'h61);
        push(32'h3, 32'h4, 32'd4, 1'b0, 8'h62);
        check("t6_queued", 64'(queue_count), 64'd2);
        check("t6_busy", 64'(busy), 64'd1);
        rstn = 1'b0;
        step();
        check("t6_rst_count", 64'(queue_count), 64'd0);
        check("t6_rst_ready", 64'(bus.cmd_ready), 64'd1);
        check("t6_rst_flags", 64'({busy, bus.sts_valid, bus.sts_zero_len, reader_start, writer_start, write_zero}), 64'd0);
        check("t6_rst_addrs", {read_start_addr, write_start_addr}, 64'd0);
        check("t6_rst_btt_tag", {btt, 24'd0, bus.sts_tag}, 64'd0);
        rstn = 1'b1;
        set_writer_intr = 1'b1;
        set_reader_intr = 1'b1;
        step();
        set_writer_intr = 1'b0;
        set_reader_intr = 1'b0;
        step();
        step();
        check("t6_no_stale_sts", 64'(bus.sts_valid), 64'd0);
        check("t6_idle", 64'(busy), 64'd0);
        check("t6_no_launch", 64'(writer_start), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
